// File: rtl/bram_pkg.sv
// bram_pkg: shared clear-FSM state type, byte-count helper and DATA_WIDTH legality limits
package bram_pkg;
  typedef enum logic {CLEAR, READY} clr_state_e;
  localparam int DW_MIN = 8;
  localparam int DW_MAX = 128;
  function automatic int bytes_of(input int dw);
    return dw / 8;
  endfunction
  function automatic bit dw_legal(input int dw);
    return (dw % 8 == 0) && (dw >= DW_MIN) && (dw <= DW_MAX);
  endfunction
endpackage

// File: rtl/bram_clear_fsm.sv
// bram_clear_fsm: walks every word address once after reset and holds busy until done
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] cnt_o
);
  clr_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  // Leave CLEAR after the last word is written; the counter wraps to 0 on that same edge
  always_comb begin
    state_d = (state_q == CLEAR && cnt_q == '1) ? READY : state_q;
    cnt_d   = (state_q == CLEAR) ? cnt_q + 1'b1 : '0;
  end
  // State and counter registers; reset restarts the clear from word 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy_o = (state_q == CLEAR);
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port block RAM with byte enables, write-first bypass and post-reset clear
module bram_sdp
  import bram_pkg::*;
#(
  parameter int    ADDR_WIDTH = 14,
  parameter int    DATA_WIDTH = 32,
  parameter int    OUT_REG    = 0,
  parameter int    INIT_CLEAR = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                          clka,
  input  logic                          rsta,
  input  logic [ADDR_WIDTH-1:0]         addra,
  input  logic [DATA_WIDTH-1:0]         dina,
  input  logic [bytes_of(DATA_WIDTH)-1:0] wea,
  input  logic                          enb,
  input  logic [ADDR_WIDTH-1:0]         addrb,
  output logic [DATA_WIDTH-1:0]         doutb,
  output logic                          doutb_valid,
  output logic                          busy
);
  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (!dw_legal(DATA_WIDTH)) begin : g_bad_dw
    $error("bram_sdp: DATA_WIDTH must be a multiple of 8 in 8..128");
  end

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] clr_cnt, waddr;
  logic [DATA_WIDTH-1:0] wdata, rd_d, d1_q;
  logic [BYTES-1:0]      we_eff;
  logic                  acc, v1_q;

  bram_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_CLEAR(INIT_CLEAR)) u_clr (
    .clk_i (clka),
    .rst_i (rsta),
    .busy_o(busy),
    .cnt_o (clr_cnt)
  );

  // The clear engine owns port A while busy; user traffic is dropped, not queued
  always_comb begin
    we_eff = rsta ? '0 : (busy ? '1 : wea);
    waddr  = busy ? clr_cnt : addra;
    wdata  = busy ? '0 : dina;
    acc    = enb & ~busy;
  end

  // Write-first per byte: bytes written this edge to the read address bypass the array
  always_comb begin
    rd_d = mem_q[addrb];
    for (int k = 0; k < BYTES; k++)
      if (wea[k] && addra == addrb) rd_d[8*k +: 8] = dina[8*k +: 8];
  end

  // Array write with per-byte enables; the array itself is never reset
  always_ff @(posedge clka) begin
    for (int k = 0; k < BYTES; k++)
      if (we_eff[k]) mem_q[waddr][8*k +: 8] <= wdata[8*k +: 8];
  end

  // First read stage; data only moves on an accepted request so the output holds otherwise
  always_ff @(posedge clka) begin
    if (rsta) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= acc;
      if (acc) d1_q <= rd_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] d2_q;
    logic                  v2_q;
    // Optional output pipeline stage with the same hold-on-idle behaviour
    always_ff @(posedge clka) begin
      if (rsta) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end
    assign doutb       = d2_q;
    assign doutb_valid = v2_q;
  end else begin : g_noreg
    assign doutb       = d1_q;
    assign doutb_valid = v1_q;
  end
endmodule
